// File: rtl/rx_block_lock_pkg.sv
// Shared PCS definitions for 64b/66b block alignment: sync header codes,
// lock-state encoding and default window sizes.
package rx_block_lock_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int LOCK_CNT_DEF    = 64;
  localparam int INVALID_MAX_DEF = 16;
  localparam int SLIP_WAIT_DEF   = 4;

  typedef enum logic [1:0] {
    LS_RESET_CNT = 2'd0,
    LS_TEST_SH   = 2'd1,
    LS_SLIP      = 2'd2,
    LS_SLIP_WAIT = 2'd3
  } lock_state_e;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// 64b/66b block lock: hunts for sync-header alignment by requesting gearbox
// bitslips, declares lock after a clean window and drops it on too many errors.
//
// state        | meaning
// LS_RESET_CNT | clear window counters, consumes no block
// LS_TEST_SH   | count headers of the current window, decide lock/slip
// LS_SLIP      | one-cycle bitslip request to the gearbox
// LS_SLIP_WAIT | discard SLIP_WAIT qualified blocks while the gearbox realigns
module rx_block_lock
  import rx_block_lock_pkg::*;
#(
  parameter int LOCK_CNT    = LOCK_CNT_DEF,
  parameter int INVALID_MAX = INVALID_MAX_DEF,
  parameter int SLIP_WAIT   = SLIP_WAIT_DEF
) (
  input  logic       i_rxc,
  input  logic       i_reset_n,
  input  logic [0:1] i_rx_header,
  input  logic       i_rx_valid,
  output logic       o_bitslip,
  output logic       o_block_lock,
  output logic [4:0] o_invalid_cnt
);

  localparam int SHW = $clog2(LOCK_CNT + 1);
  localparam int SWW = $clog2(SLIP_WAIT + 1);
  localparam logic [SHW-1:0] SH_LIMIT  = SHW'(LOCK_CNT);
  localparam logic [4:0]     INV_LIMIT = 5'(INVALID_MAX);
  localparam logic [SWW-1:0] SW_LAST   = SWW'(SLIP_WAIT - 1);

  lock_state_e    state_q, state_d;
  logic [SHW-1:0] sh_cnt_q, sh_cnt_d, sh_inc;
  logic [4:0]     inv_cnt_q, inv_cnt_d, inv_inc;
  logic [SWW-1:0] slip_cnt_q, slip_cnt_d;
  logic           lock_q, lock_d;
  logic           bitslip_q, bitslip_d;
  logic           hdr_ok;

  assign hdr_ok = sh_is_valid(i_rx_header);

  // Saturating increments so neither counter can ever wrap.
  always_comb begin
    sh_inc  = (sh_cnt_q == SH_LIMIT) ? sh_cnt_q : sh_cnt_q + 1'b1;
    inv_inc = inv_cnt_q;
    if (!hdr_ok && (inv_cnt_q < INV_LIMIT)) begin
      inv_inc = inv_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    slip_cnt_d = slip_cnt_q;
    lock_d     = lock_q;
    bitslip_d  = 1'b0;
    case (state_q)
      LS_RESET_CNT: begin
        sh_cnt_d   = '0;
        inv_cnt_d  = '0;
        slip_cnt_d = '0;
        state_d    = LS_TEST_SH;
      end
      LS_TEST_SH: begin
        if (i_rx_valid) begin
          sh_cnt_d  = sh_inc;
          inv_cnt_d = inv_inc;
          if (lock_q) begin
            // Lock loss takes priority over a window completing on the same block.
            if (inv_inc >= INV_LIMIT) begin
              lock_d  = 1'b0;
              state_d = LS_SLIP;
            end else if (sh_inc == SH_LIMIT) begin
              state_d = LS_RESET_CNT;
            end
          end else if (!hdr_ok) begin
            state_d = LS_SLIP;
          end else if ((sh_inc == SH_LIMIT) && (inv_cnt_q == '0)) begin
            lock_d  = 1'b1;
            state_d = LS_RESET_CNT;
          end
        end
      end
      LS_SLIP: begin
        bitslip_d  = 1'b1;
        slip_cnt_d = '0;
        state_d    = LS_SLIP_WAIT;
      end
      LS_SLIP_WAIT: begin
        if (i_rx_valid) begin
          if (slip_cnt_q == SW_LAST) begin
            slip_cnt_d = '0;
            state_d    = LS_RESET_CNT;
          end else begin
            slip_cnt_d = slip_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LS_RESET_CNT;
    endcase
  end

  always_ff @(posedge i_rxc) begin
    if (!i_reset_n) begin
      state_q    <= LS_RESET_CNT;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      slip_cnt_q <= '0;
      lock_q     <= 1'b0;
      bitslip_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      slip_cnt_q <= slip_cnt_d;
      lock_q     <= lock_d;
      bitslip_q  <= bitslip_d;
    end
  end

  assign o_bitslip     = bitslip_q;
  assign o_block_lock  = lock_q;
  assign o_invalid_cnt = inv_cnt_q;

endmodule

// File: doc/rx_block_lock.md
RX_BLOCK_LOCK -- requirements
Module: rx_block_lock

Interface
REQ-001 Parameter LOCK_CNT, default 64: valid headers required per test window.
REQ-002 Parameter INVALID_MAX, default 16: invalid headers within one window that cause lock loss.
REQ-003 Parameter SLIP_WAIT, default 4: qualified blocks ignored after each bitslip, letting the gearbox realign.
REQ-004 i_rxc  in  1  RX clock; the block has one clock and is synchronous to its rising edge.
REQ-005 i_reset_n  in  1  reset; synchronous, active-low.
REQ-006 i_rx_header  in  [0:1]  sync header of the current 66-bit block from the RX gearbox (bits 0:1 of rxd).
REQ-007 i_rx_valid  in  1  qualifies i_rx_header; low during gearbox pause cycles.
REQ-008 o_bitslip  out  1  one-cycle pulse requesting a one-bit slip from the gearbox.
REQ-009 o_block_lock  out  1  block alignment achieved; gates the decoder.
REQ-010 o_invalid_cnt  out  5  invalid headers counted in the current window, for status.

Function
REQ-011 A header is valid when i_rx_header is 2'b01 (data) or 2'b10 (control); 2'b00 and 2'b11 are invalid.
REQ-012 Only cycles with i_rx_valid=1 are qualified blocks; all counters and state SHALL hold when i_rx_valid=0.
REQ-013 The FSM SHALL have four states: RESET_CNT, TEST_SH, SLIP, SLIP_WAIT.
REQ-014 RESET_CNT: clear sh_cnt and invalid_cnt; go to TEST_SH next cycle unconditionally.
  - RESET_CNT consumes no block.
  - A block arriving during RESET_CNT is not counted.
REQ-015 In TEST_SH, each qualified block SHALL increment sh_cnt, and each invalid block SHALL also increment invalid_cnt.
REQ-016 Unlocked, TEST_SH:
  - First invalid header -> SLIP.
  - sh_cnt reaching LOCK_CNT with invalid_cnt=0 -> set o_block_lock; go to RESET_CNT.
REQ-017 Locked, TEST_SH:
  - invalid_cnt reaching INVALID_MAX -> clear o_block_lock; go to SLIP.
  - Otherwise, sh_cnt reaching LOCK_CNT -> RESET_CNT, lock retained.
  - If both conditions occur on the same block, lock loss wins.
REQ-018 SLIP SHALL drive o_bitslip=1 for exactly one cycle, then go to SLIP_WAIT.
REQ-019 SLIP_WAIT SHALL discard SLIP_WAIT qualified blocks (counter limit SLIP_WAIT-1), then go to RESET_CNT.
REQ-020 All outputs SHALL be registered.
  - o_bitslip rises on the edge after the edge sampling the triggering header.
  - o_block_lock changes on the edge sampling the deciding header.
REQ-021 sh_cnt width SHALL be $clog2(LOCK_CNT+1); counters SHALL never wrap.
  - invalid_cnt saturates at INVALID_MAX.
REQ-022 o_invalid_cnt SHALL mirror invalid_cnt, which is zeroed in RESET_CNT.

Reset
REQ-023 When i_reset_n=0 at a rising i_rxc edge, the block SHALL enter RESET_CNT.
  - o_block_lock=0, o_bitslip=0, o_invalid_cnt=0.
  - All counters cleared.
REQ-024 Reset mid-operation, including during SLIP or SLIP_WAIT, SHALL abort any pending slip and discard lock.
  - No o_bitslip pulse SHALL occur in the cycle after reset deasserts.

Structure
REQ-025 Shared PCS package SHALL hold:
  - SH_DATA=2'b01, SH_CTRL=2'b10.
  - The lock-state enum.
  - Defaults for LOCK_CNT and INVALID_MAX.
REQ-026 The block SHALL be a single module with no sub-module.
  - Instantiated between the RX gearbox and the 64b/66b decoder.
  - o_bitslip connects to the gearbox slip input.

Verification
REQ-027 Bench SHALL cover these scenarios:
  - Lock acquisition: 64 consecutive qualified 2'b01/2'b10 headers after reset -> o_block_lock=1 on the 64th; no o_bitslip.
  - Misalignment: header 2'b11 on block 10 while unlocked -> one o_bitslip pulse, 4 blocks ignored, then counting restarts from 0.
  - Lock loss: while locked, 16 invalid among 40 blocks of one window -> o_block_lock=0 on the 16th invalid, then o_bitslip.
  - Lock hold: while locked, 15 invalid per 64-block window for 3 windows -> o_block_lock stays 1; o_invalid_cnt returns to 0 each window.
  - Pause: i_rx_valid=0 for 1 cycle in every 33 during acquisition -> lock exactly on the 64th qualified block; pause cycles not counted.
  - Reset mid-SLIP_WAIT: i_reset_n=0 for 1 cycle -> all outputs 0; clean reacquisition after 64 valid blocks.
REQ-028 Bench SHALL model gearbox realignment: a behavioral slipping source reaches lock within 66 slips from any offset.
